// File: rtl/sat_updown_counter_p_if.sv
`default_nettype none
// ============================================================================
// Module      : sat_updown_counter_p_if
// Description : Control/status bundle for sat_updown_counter_p.
//               The master drives load/a/step/up/dn/lo/hi/wrap/clr_flags.
//               The slave (the counter) returns q, at_max, at_min, ovf, unf,
//               evt and cfg_err.
// Revision    : 1.0 - initial release
// ============================================================================
interface sat_updown_counter_p_if #(
    parameter int WIDTH = 8
);
    logic             load;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] step;
    logic             up;
    logic             dn;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic             wrap;
    logic             clr_flags;
    logic [WIDTH-1:0] q;
    logic             at_max;
    logic             at_min;
    logic             ovf;
    logic             unf;
    logic             evt;
    logic             cfg_err;

    modport master (
        output load, a, step, up, dn, lo, hi, wrap, clr_flags,
        input  q, at_max, at_min, ovf, unf, evt, cfg_err
    );

    modport slave (
        input  load, a, step, up, dn, lo, hi, wrap, clr_flags,
        output q, at_max, at_min, ovf, unf, evt, cfg_err
    );
endinterface
`default_nettype wire

// File: rtl/sat_updown_counter_p.sv
`default_nettype none
// ============================================================================
// Module      : sat_updown_counter_p
// Description : Signed up/down counter with runtime bounds [lo, hi].
//               Each enabled cycle adds (up) or subtracts (dn) a signed step.
//               An overshoot either saturates at the crossed bound or wraps
//               to the opposite bound, depending on wrap.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               bus (slave)     - load/a        : load clamped value
//                                 step/up/dn    : signed step control
//                                 lo/hi         : inclusive signed bounds
//                                 wrap          : 0 saturate, 1 wrap
//                                 clr_flags     : clear sticky ovf/unf
//                                 q             : registered count
//                                 at_max/at_min : q at hi / lo
//                                 ovf/unf       : sticky overshoot flags
//                                 evt           : one-cycle event pulse
//                                 cfg_err       : lo > hi
// Revision    : 1.0 - initial release
// ============================================================================
module sat_updown_counter_p #(
    parameter int WIDTH = 8
) (
    input  wire                    clk,
    input  wire                    rst,
    sat_updown_counter_p_if.slave  bus
);
    // Two guard bits: q +/- step cannot overflow, and -(most-negative) is exact.
    localparam int XW = WIDTH + 2;

    logic [WIDTH-1:0] r_q;
    logic             r_ovf;
    logic             r_unf;
    logic             r_evt;

    logic signed [XW-1:0] w_q_x;
    logic signed [XW-1:0] w_a_x;
    logic signed [XW-1:0] w_step_x;
    logic signed [XW-1:0] w_lo_x;
    logic signed [XW-1:0] w_hi_x;
    logic signed [XW-1:0] w_r_x;
    logic                 w_step_en;
    logic                 w_cfg_err;

    logic [WIDTH-1:0] w_q_nxt;
    logic             w_ovf_nxt;
    logic             w_unf_nxt;
    logic             w_evt_nxt;

    assign w_q_x    = {{2{r_q[WIDTH-1]}},      r_q};
    assign w_a_x    = {{2{bus.a[WIDTH-1]}},    bus.a};
    assign w_step_x = {{2{bus.step[WIDTH-1]}}, bus.step};
    assign w_lo_x   = {{2{bus.lo[WIDTH-1]}},   bus.lo};
    assign w_hi_x   = {{2{bus.hi[WIDTH-1]}},   bus.hi};

    assign w_step_en = bus.up ^ bus.dn;
    assign w_r_x     = bus.up ? (w_q_x + w_step_x) : (w_q_x - w_step_x);
    assign w_cfg_err = (w_lo_x > w_hi_x);

    always_comb begin
        w_q_nxt   = r_q;
        w_ovf_nxt = r_ovf & ~bus.clr_flags;
        w_unf_nxt = r_unf & ~bus.clr_flags;
        w_evt_nxt = 1'b0;

        if (w_cfg_err) begin
            // Inconsistent bounds: freeze the count, only clr_flags acts.
            w_q_nxt = r_q;
        end else if (bus.load) begin
            if (w_a_x > w_hi_x)
                w_q_nxt = bus.hi;
            else if (w_a_x < w_lo_x)
                w_q_nxt = bus.lo;
            else
                w_q_nxt = bus.a;
        end else if (w_step_en) begin
            if (w_r_x > w_hi_x) begin
                w_q_nxt   = bus.wrap ? bus.lo : bus.hi;
                w_ovf_nxt = 1'b1;   // set wins over a simultaneous clear
                w_evt_nxt = 1'b1;
            end else if (w_r_x < w_lo_x) begin
                w_q_nxt   = bus.wrap ? bus.hi : bus.lo;
                w_unf_nxt = 1'b1;
                w_evt_nxt = 1'b1;
            end else begin
                w_q_nxt = w_r_x[WIDTH-1:0];
            end
        end else if (w_q_x > w_hi_x) begin
            // Bounds moved under an idle counter: pull q in silently.
            w_q_nxt = bus.hi;
        end else if (w_q_x < w_lo_x) begin
            w_q_nxt = bus.lo;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q   <= '0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
            r_evt <= 1'b0;
        end else begin
            r_q   <= w_q_nxt;
            r_ovf <= w_ovf_nxt;
            r_unf <= w_unf_nxt;
            r_evt <= w_evt_nxt;
        end
    end

    assign bus.q       = r_q;
    assign bus.ovf     = r_ovf;
    assign bus.unf     = r_unf;
    assign bus.evt     = r_evt;
    assign bus.at_max  = (r_q == bus.hi);
    assign bus.at_min  = (r_q == bus.lo);
    assign bus.cfg_err = w_cfg_err;
endmodule
`default_nettype wire

// File: tb/tb_sat_updown_counter_p.sv
`default_nettype none
// ============================================================================
// Module      : tb_sat_updown_counter_p
// Description : Directed self-checking bench for sat_updown_counter_p
//               (WIDTH = 8) with hand-computed expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sat_updown_counter_p;
    localparam int WIDTH = 8;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    sat_updown_counter_p_if #(.WIDTH(WIDTH)) bus ();

    sat_updown_counter_p #(.WIDTH(WIDTH)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; outputs are then sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_q(input string tag, input int exp);
        check(tag, int'($signed(bus.q)), exp);
    endtask

    task automatic chk_flags(input string tag, input int e_ovf, input int e_unf, input int e_evt);
        check({tag, ".ovf"}, int'(bus.ovf), e_ovf);
        check({tag, ".unf"}, int'(bus.unf), e_unf);
        check({tag, ".evt"}, int'(bus.evt), e_evt);
    endtask

    task automatic set_bounds(input int l, input int h);
        bus.lo = WIDTH'(l);
        bus.hi = WIDTH'(h);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        bus.load = 1'b0; bus.a = '0; bus.step = '0;
        bus.up = 1'b0; bus.dn = 1'b0; bus.wrap = 1'b0; bus.clr_flags = 1'b0;
        set_bounds(-100, 100);

        // Reset state
        tick(); tick();
        chk_q("rst.q", 0);
        chk_flags("rst", 0, 0, 0);
        check("rst.cfg_err", int'(bus.cfg_err), 0);
        rst = 1'b0;

        // 1: saturate at hi
        bus.load = 1'b1; bus.a = 8'sd90;
        tick(); chk_q("t1.load", 90);
        bus.load = 1'b0; bus.step = 8'sd5; bus.up = 1'b1;
        tick(); chk_q("t1.c1", 95);  check("t1.c1.evt", int'(bus.evt), 0);
        tick(); chk_q("t1.c2", 100); check("t1.c2.evt", int'(bus.evt), 0);
        check("t1.c2.at_max", int'(bus.at_max), 1);
        check("t1.c2.ovf", int'(bus.ovf), 0);
        tick(); chk_q("t1.c3", 100); chk_flags("t1.c3", 1, 0, 1);
        bus.up = 1'b0;
        tick(); chk_flags("t1.idle", 1, 0, 0);

        // 2: wrap mode overshoot then undershoot (back-to-back evt)
        bus.wrap = 1'b1; bus.load = 1'b1; bus.a = 8'sd98;
        tick(); chk_q("t2.load", 98);
        bus.load = 1'b0; bus.up = 1'b1;
        tick(); chk_q("t2.ovf", -100); chk_flags("t2.ovf", 1, 0, 1);
        check("t2.at_min", int'(bus.at_min), 1);
        bus.up = 1'b0; bus.dn = 1'b1; bus.step = 8'sd1;
        tick(); chk_q("t2.unf", 100); chk_flags("t2.unf", 1, 1, 1);
        bus.dn = 1'b0; bus.wrap = 1'b0; bus.clr_flags = 1'b1;
        tick(); chk_flags("t2.clr", 0, 0, 0);
        bus.clr_flags = 1'b0;

        // 3: full range, most-negative step negated exactly
        set_bounds(-128, 127);
        bus.load = 1'b1; bus.a = 8'h80;
        tick(); chk_q("t3.load", -128);
        bus.load = 1'b0; bus.step = 8'h80; bus.dn = 1'b1;
        tick(); chk_q("t3.negmin", 0); chk_flags("t3.negmin", 0, 0, 0);
        bus.dn = 1'b0; bus.up = 1'b1; bus.step = 8'sd127;
        tick(); chk_q("t3.up1", 127); chk_flags("t3.up1", 0, 0, 0);
        tick(); chk_q("t3.up2", 127); chk_flags("t3.up2", 1, 0, 1);

        // 4: up=dn=1 holds; load clamps without flags
        bus.dn = 1'b1; bus.step = 8'sd10;
        tick(); chk_q("t4.both", 127); check("t4.both.evt", int'(bus.evt), 0);
        bus.up = 1'b0; bus.dn = 1'b0;
        set_bounds(-100, 100);
        bus.load = 1'b1; bus.a = 8'sd120;
        tick(); chk_q("t4.clampload", 100); chk_flags("t4.clampload", 1, 0, 0);
        bus.load = 1'b0;

        // Saturating underflow with a negative step on up
        bus.load = 1'b1; bus.a = -8'sd95;
        tick(); chk_q("t4.load2", -95);
        bus.load = 1'b0; bus.up = 1'b1; bus.step = -8'sd10;
        tick(); chk_q("t4.unfsat", -100); chk_flags("t4.unfsat", 1, 1, 1);
        bus.up = 1'b0; bus.load = 1'b1; bus.a = 8'sd100;
        tick(); chk_q("t4.reload", 100);
        bus.load = 1'b0;

        // 5: set beats clear; then clear alone; then cfg_err freezes
        bus.clr_flags = 1'b1; bus.up = 1'b1; bus.step = 8'sd5;
        tick(); chk_q("t5.set", 100); chk_flags("t5.set", 1, 0, 1);
        bus.up = 1'b0;
        tick(); chk_flags("t5.clr", 0, 0, 0);
        bus.clr_flags = 1'b0;
        set_bounds(10, 5);
        #1; check("t5.cfg_err", int'(bus.cfg_err), 1);
        bus.up = 1'b1; bus.step = 8'sd1;
        tick(); chk_q("t5.cfg.up", 100); chk_flags("t5.cfg.up", 0, 0, 0);
        bus.up = 1'b0; bus.load = 1'b1; bus.a = 8'sd7;
        tick(); chk_q("t5.cfg.load", 100);
        bus.load = 1'b0;

        // 6: bound change clamps silently; mid-sequence reset
        set_bounds(-100, 100);
        #1; check("t6.cfg_ok", int'(bus.cfg_err), 0);
        bus.load = 1'b1; bus.a = 8'sd50;
        tick(); chk_q("t6.load", 50);
        bus.load = 1'b0; set_bounds(-100, 20);
        tick(); chk_q("t6.clamp", 20); chk_flags("t6.clamp", 0, 0, 0);
        check("t6.at_max", int'(bus.at_max), 1);
        bus.up = 1'b1; bus.step = 8'sd5;
        tick(); chk_q("t6.sat", 20); chk_flags("t6.sat", 1, 0, 1);
        rst = 1'b1;
        tick(); chk_q("t6.rst", 0); chk_flags("t6.rst", 0, 0, 0);
        rst = 1'b0; bus.up = 1'b0;
        tick(); chk_q("t6.post", 0); chk_flags("t6.post", 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1);
    end
endmodule
`default_nettype wire
